// File: rtl/ram_bank_scheduler.sv
// ram_bank_scheduler: passes RAM banks round a FREE -> FILLED -> PROCESSED ring
// between the fill, process and drain stages of the SD encrypt/decrypt flow.
// Each stage requests a bank, holds it while its grant is high and releases it
// with a one-cycle done pulse. A released bank becomes the downstream stage's.
module ram_bank_scheduler #(
  parameter int NBANKS = 4
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       iflush,
  input  logic       ifill_req,
  input  logic       iproc_req,
  input  logic       idrain_req,
  input  logic       ifill_done,
  input  logic       iproc_done,
  input  logic       idrain_done,
  output logic       ofill_grant,
  output logic       oproc_grant,
  output logic       odrain_grant,
  output logic [2:0] ofill_bank,
  output logic [2:0] oproc_bank,
  output logic [2:0] odrain_bank,
  output logic [3:0] ofree_cnt,
  output logic [3:0] ofilled_cnt,
  output logic [3:0] oproc_cnt,
  output logic       oidle,
  output logic       oerr
);

  // Stage index s: 0 = fill, 1 = process, 2 = drain.
  // Class index c: 0 = free, 1 = filled, 2 = processed.
  // Stage s takes banks from class s and releases them into class (s+1) mod 3.
  localparam int         NST       = 3;
  localparam logic [2:0] LAST_BANK = 3'(NBANKS - 1);
  localparam logic [3:0] FULL_CNT  = 4'(NBANKS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } stage_st_t;

  stage_st_t  r_st   [NST];
  logic [2:0] r_ptr  [NST];
  logic [2:0] r_bank [NST];
  logic [3:0] r_cnt  [NST];
  logic       r_err;
  logic       r_idle;

  logic [NST-1:0] w_req;
  logic [NST-1:0] w_done;
  logic [NST-1:0] w_grant;
  logic [NST-1:0] w_release;
  logic [NST-1:0] w_bad_done;
  logic [NST-1:0] w_held_nxt;
  logic [3:0]     w_cnt_nxt [NST];
  logic           w_idle_nxt;

  assign w_req  = {idrain_req, iproc_req, ifill_req};
  assign w_done = {idrain_done, iproc_done, ifill_done};

  // Per-stage grant/release decisions and the next class counts.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_grant    = '0;
    w_release  = '0;
    w_bad_done = '0;
    w_held_nxt = '0;
    for (int s = 0; s < NST; s++) begin
      w_grant[s]    = (r_st[s] == ST_IDLE) && w_req[s] && (r_cnt[s] != 4'd0);
      w_release[s]  = (r_st[s] == ST_HELD) && w_done[s];
      w_bad_done[s] = (r_st[s] == ST_IDLE) && w_done[s];
      w_held_nxt[s] = w_grant[s] || ((r_st[s] == ST_HELD) && !w_done[s]);
    end
    // A class gains a bank when its upstream stage releases and loses one
    // when its consuming stage is granted; both in one cycle cancel out.
    w_cnt_nxt[0] = r_cnt[0] + {3'b000, w_release[2]} - {3'b000, w_grant[0]};
    w_cnt_nxt[1] = r_cnt[1] + {3'b000, w_release[0]} - {3'b000, w_grant[1]};
    w_cnt_nxt[2] = r_cnt[2] + {3'b000, w_release[1]} - {3'b000, w_grant[2]};
    w_idle_nxt   = (w_cnt_nxt[0] == FULL_CNT) && (w_held_nxt == '0);
  end

  // Stage FSMs, ring pointers, class counters and status flags.
  always_ff @(posedge iclk or posedge irst) begin
    // NOTE: the bank registers are reset along with the rest so the bank
    // outputs read 0 out of reset, as the downstream mux expects.
    if (irst) begin
      for (int s = 0; s < NST; s++) begin
        r_st[s]   <= ST_IDLE;
        r_ptr[s]  <= '0;
        r_bank[s] <= '0;
      end
      r_cnt[0] <= FULL_CNT;
      r_cnt[1] <= '0;
      r_cnt[2] <= '0;
      r_err    <= 1'b0;
      r_idle   <= 1'b1;
    end else if (iflush) begin
      for (int s = 0; s < NST; s++) begin
        r_st[s]   <= ST_IDLE;
        r_ptr[s]  <= '0;
        r_bank[s] <= '0;
      end
      r_cnt[0] <= FULL_CNT;
      r_cnt[1] <= '0;
      r_cnt[2] <= '0;
      r_err    <= 1'b0;
      r_idle   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from values sampled at the same edge.
      for (int s = 0; s < NST; s++) begin
        if (w_grant[s]) begin
          r_st[s]   <= ST_HELD;
          r_bank[s] <= r_ptr[s];
        end else if (w_release[s]) begin
          r_st[s]  <= ST_IDLE;
          r_ptr[s] <= (r_ptr[s] == LAST_BANK) ? 3'd0 : r_ptr[s] + 3'd1;
        end
        r_cnt[s] <= w_cnt_nxt[s];
      end
      if (|w_bad_done) begin
        r_err <= 1'b1;
      end
      r_idle <= w_idle_nxt;
    end
  end

  assign ofill_grant  = (r_st[0] == ST_HELD);
  assign oproc_grant  = (r_st[1] == ST_HELD);
  assign odrain_grant = (r_st[2] == ST_HELD);
  assign ofill_bank   = r_bank[0];
  assign oproc_bank   = r_bank[1];
  assign odrain_bank  = r_bank[2];
  assign ofree_cnt    = r_cnt[0];
  assign ofilled_cnt  = r_cnt[1];
  assign oproc_cnt    = r_cnt[2];
  assign oidle        = r_idle;
  assign oerr         = r_err;

endmodule

// File: doc/ram_bank_scheduler.md
# ram_bank_scheduler

Schedules ownership of the RAM bank pool between the three data stages of the SD encrypt/decrypt flow: fill (D-line read from card), process (OTP XOR) and drain (D-line write back to card). Banks circulate in a strict ring: FREE -> FILLED -> PROCESSED -> FREE. Each stage requests a bank, receives a grant with a bank number, and releases the bank with a done pulse. The block sits between `sd_fsm`/`d_driver` and the RAM select mux, and drives the bank numbers used as `osel_ram`.

## Interface
Parameters:
- `NBANKS`, default 4: banks in the ring; legal range 2..8.

Ports:
- `iclk`  in  1  system clock (36 MHz); the only clock.
- `irst`  in  1  asynchronous, active-high reset.
- `iflush`  in  1  synchronous flush: return to reset state.
- `ifill_req`, `iproc_req`, `idrain_req`  in  1 each  stage requests a bank (level).
- `ifill_done`, `iproc_done`, `idrain_done`  in  1 each  stage releases its held bank (1-cycle pulse).
- `ofill_grant`, `oproc_grant`, `odrain_grant`  out  1 each  stage holds a bank (level).
- `ofill_bank`, `oproc_bank`, `odrain_bank`  out  3 each  bank held by that stage; valid while its grant is high.
- `ofree_cnt`, `ofilled_cnt`, `oproc_cnt`  out  4 each  banks waiting in each class, excluding banks currently held.
- `oidle`  out  1  all NBANKS banks free and no grant active.
- `oerr`  out  1  sticky protocol error.

## Operation
- State: three ring pointers (`fill_ptr`, `proc_ptr`, `drain_ptr`, each mod NBANKS), three counters, and a per-stage 2-state FSM with states IDLE and HELD.
- Reset and flush values: pointers 0; `ofree_cnt`=NBANKS; other counters 0; all stages IDLE; all grants 0; all banks 0; `oerr` 0; `oidle` 1.
- Grant rules:
  - Fill: IDLE -> HELD when `ifill_req` is high and `ofree_cnt`>0. On grant, `ofill_bank`<=`fill_ptr` and `ofree_cnt` decrements.
  - Process: same rule using `iproc_req`, `ofilled_cnt` and `proc_ptr`.
  - Drain: same rule using `idrain_req`, `oproc_cnt` and `drain_ptr`.
- Release rules:
  - Fill: HELD -> IDLE on `ifill_done`. The pointer advances (wrapping NBANKS-1 -> 0), and the downstream class counter increments.
  - Process: `iproc_done` increments `oproc_cnt`.
  - Drain: `idrain_done` increments `ofree_cnt`.
- Ordering: because banks only advance stage to stage in ring order, each stage receives banks in 0,1,..,NBANKS-1,0,... order. A stage can never be granted a bank owned by another stage.
- Simultaneous events:
  - Grants and releases in the same cycle on different stages are all honoured.
  - A counter that sees an increment and a decrement in the same cycle keeps its value.
  - A release makes its bank available to the downstream stage from the next cycle.
- Request drop: dropping `*_req` while IDLE has no effect. Dropping it while HELD does not release the bank; only `*_done` releases.
- Protocol errors: `*_done` while that stage is IDLE sets `oerr` and is otherwise ignored; no counter or pointer changes.
- `oidle` = (`ofree_cnt`==NBANKS) and no grant high. It is registered, derived from the next-state values.
- `iflush` has priority over every other input in the same cycle.
- `irst` asserted mid-operation immediately forces the reset values, independent of the clock.

## Timing
- All outputs are registered.
- Grant latency: a request sampled high at edge N, with resources available, gives grant and bank valid after edge N. This is one cycle.
- `*_done` at edge N: grant low after edge N, and the counter is updated after edge N.
- Back-to-back use: a stage that releases at edge N can be re-granted at edge N+1 at the earliest. There is one IDLE cycle minimum.
- Throughput: each stage can hold a new bank every 2 cycles in steady state.
- Bank numbers are stable for the whole HELD interval.

## Test plan
- Reset, NBANKS=4 -> `ofree_cnt`=4, other counts 0, `oidle`=1, grants 0. Then pulse `irst` while a bank is held -> same values.
- Fill request held high, done pulsed 1 cycle after each grant -> banks 0,1,2,3 granted. The fifth request stays ungranted with `ofree_cnt`=0 and `ofilled_cnt`=4.
- Full pipeline over 10 banks, with all three stages requesting continuously and done issued 3 cycles after each grant:
  - Each stage sees banks 0,1,2,3,0,1,...
  - No two stages ever hold the same bank.
  - Counts plus held banks sum to 4 on every cycle.
- Same-cycle `iproc_done` and `idrain_req` grant with `oproc_cnt`=1 -> drain is granted. Then `oproc_cnt` ends at 1 (+1 -1 = net 0 plus the released bank).
- `idrain_done` while drain is IDLE -> `oerr`=1 and stays 1. Counters are unchanged. `iflush` clears `oerr` and restores the reset values.
- Process request with `ofilled_cnt`=0 -> no grant for 20 cycles. A fill done then makes `oproc_grant` rise 1 cycle later, with `oproc_bank`=0.
